bar_key_scheduler: RTL and testbench
====================================

// Module: bar_key_scheduler
// PURPOSE
//  Schedules which synthesizer key bars are highlighted on the VGA display.
//  Two note requesters share the highlight resource: the keyboard decoder and the demo player.
//  A round-robin arbiter grants them. Each bar has a per-bar hold timer counted in frames.
//  The lit-bar vector is double-buffered and updates only on frame_tick, so it never tears mid-frame.
//  The bar-region decoder uses bar_lit to choose highlight colour.
//  Bar index map: 0=Hu4 1=Hu2 2=Hu1 3=Mu6 4=Mu5 5=Mu4 6=Mu2 7=Mu1 8=Lu6 9=Lu5 10=Lu4.
// PARAMETERS
//  NUM_BARS     11  number of key bars; legal bar indices are 0..NUM_BARS-1
//  HOLD_FRAMES  8   frames a bar stays lit after its grant (1..2^CNT_W-1)
//  CNT_W        4   width of each hold counter
// PORTS
//  clk         in   1         system clock (VGA pixel clock domain)
//  reset       in   1         synchronous, active-high reset
//  frame_tick  in   1         one-cycle pulse at start of vertical blank
//  kb_req      in   1         keyboard note request; held until kb_ack
//  kb_bar      in   4         keyboard bar index; stable while kb_req=1
//  kb_ack      out  1         one-cycle grant acknowledge to keyboard
//  demo_en     in   1         0 masks demo_req completely (demo_req is never acked)
//  demo_req    in   1         demo-player note request; held until demo_ack
//  demo_bar    in   4         demo bar index; stable while demo_req=1
//  demo_ack    out  1         one-cycle grant acknowledge to demo player
//  clear_req   in   1         pulse: all-notes-off
//  busy        out  1         1 while the clear sequence runs
//  bar_lit     out  NUM_BARS  displayed highlight vector; changes only on frame_tick
//  note_valid  out  1         one-cycle pulse to the audio path per accepted note
//  note_bar    out  4         bar index of the last accepted note
//  bad_idx     out  1         one-cycle pulse when a granted index is >= NUM_BARS
// BEHAVIOUR
//  Reset:
//   - all outputs 0, all counters 0, FSM=IDLE, rr pointer = keyboard.
//  FSM IDLE:
//   - Each cycle, sample eligible requests. A request is eligible if req=1, its ack is not
//     currently high, and (for demo) demo_en=1.
//   - One eligible request: grant it.
//   - Both eligible: grant the requester the rr pointer selects, then flip the pointer.
//   - No eligible request: rr pointer unchanged.
//  Grant sampled in cycle N; all effects appear in cycle N+1:
//   - The matching ack, note_valid and note_bar (registered) assert.
//   - cnt[bar] is loaded with HOLD_FRAMES.
//   - Index >= NUM_BARS: ack is still given; bad_idx=1 instead of note_valid; no counter changes.
//  frame_tick:
//   - Every nonzero cnt decrements by 1, saturating at 0.
//   - In the same cycle, bar_lit[i] <= (cnt_next[i] != 0), where cnt_next includes that cycle's
//     load and decrement.
//  Load and frame_tick on the same bar in the same cycle:
//   - The load wins: cnt = HOLD_FRAMES, not decremented, and bar_lit[i]=1.
//   - A re-grant to a lit bar reloads its counter (extends the hold).
//  clear_req in IDLE moves the FSM to CLEAR:
//   - busy=1. An index counter zeroes cnt[0..NUM_BARS-1], one per cycle, over NUM_BARS cycles.
//   - No grants are made; requests wait and are not lost.
//   - frame_tick still decrements counters and updates bar_lit.
//   - After index NUM_BARS-1, return to IDLE; busy drops the following cycle.
//  clear_req while in CLEAR: ignored.
//  clear_req and a grantable request in the same IDLE cycle: clear wins; no ack.
//  Reset asserted mid-CLEAR or mid-handshake: immediate return to reset state; pending acks are
//  dropped.
//  Hold length: a bar stays lit for HOLD_FRAMES frame_ticks after the first tick following its
//  grant, unless it is reloaded or cleared.
// STRUCTURE
//  bar_sched_pkg:
//   - NUM_BARS, BAR_IDX_W=4, CNT_W, HOLD_FRAMES defaults.
//   - Bar index constants BAR_HU4..BAR_LU4.
//   - FSM state encoding ST_IDLE and ST_CLEAR.
//  Sub-module rr_arb2:
//   - 2-way round-robin arbiter with a registered pointer.
//   - Inputs: req[1:0]. Outputs: one-hot gnt[1:0]. Pointer advances only when gnt != 0.
//  Top level holds:
//   - the counter array, the FSM with its clear index, and the bar_lit shadow register.
// TESTING
//  1. Reset, then kb_req with kb_bar=3 -> kb_ack and note_valid pulse 1 cycle later,
//     note_bar=3. Then 1 frame_tick -> bar_lit=11'h008. After 8 more ticks -> bar_lit=0.
//  2. kb_req and demo_req (demo_en=1) both held, bars 1 and 9 -> keyboard acked first,
//     demo acked next eligible cycle. Next tick -> bar_lit=11'h202.
//  3. demo_en=0 with demo_req held for 20 cycles -> demo_ack never asserts.
//     Raise demo_en -> demo_ack within 2 cycles.
//  4. kb_bar=12 -> kb_ack=1 and bad_idx=1; note_valid=0; bar_lit unchanged.
//  5. Bars 0..10 all lit, then clear_req -> busy=1 for 11 cycles; a kb_req raised during
//     the clear is acked only after busy drops. Next tick -> bar_lit = only that new bar.
//  6. Grant to bar 5 lands in the frame_tick cycle -> cnt[5]=8 and bar_lit[5]=1 that cycle.
//     A reset pulse mid-hold -> bar_lit=0 next cycle.

Source files
------------

// File: rtl/bar_key_scheduler_pkg.sv
// Shared constants, bar index map and FSM encoding for the key-bar highlight scheduler.
// Default sizing matches the 11-bar synthesizer keyboard display.
package bar_key_scheduler_pkg;

  localparam int DEF_NUM_BARS    = 11;
  localparam int BAR_IDX_W       = 4;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_HOLD_FRAMES = 8;

  typedef logic [BAR_IDX_W-1:0] bar_idx_t;

  localparam bar_idx_t BAR_HU4 = 4'd0;
  localparam bar_idx_t BAR_HU2 = 4'd1;
  localparam bar_idx_t BAR_HU1 = 4'd2;
  localparam bar_idx_t BAR_MU6 = 4'd3;
  localparam bar_idx_t BAR_MU5 = 4'd4;
  localparam bar_idx_t BAR_MU4 = 4'd5;
  localparam bar_idx_t BAR_MU2 = 4'd6;
  localparam bar_idx_t BAR_MU1 = 4'd7;
  localparam bar_idx_t BAR_LU6 = 4'd8;
  localparam bar_idx_t BAR_LU5 = 4'd9;
  localparam bar_idx_t BAR_LU4 = 4'd10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } sched_state_t;

  function automatic logic bar_in_range(input bar_idx_t idx, input int n);
    return int'(idx) < n;
  endfunction

endpackage

// File: rtl/bar_key_scheduler_if.sv
// Request/ack, clear and display signals between note sources and the bar scheduler.
// master = requesters/display side, slave = scheduler.
interface bar_key_scheduler_if #(
  parameter int N_BARS = bar_key_scheduler_pkg::DEF_NUM_BARS
);

  logic                              frame_tick;
  logic                              kb_req;
  bar_key_scheduler_pkg::bar_idx_t   kb_bar;
  logic                              kb_ack;
  logic                              demo_en;
  logic                              demo_req;
  bar_key_scheduler_pkg::bar_idx_t   demo_bar;
  logic                              demo_ack;
  logic                              clear_req;
  logic                              busy;
  logic [N_BARS-1:0]                 bar_lit;
  logic                              note_valid;
  bar_key_scheduler_pkg::bar_idx_t   note_bar;
  logic                              bad_idx;

  modport master (
    output frame_tick, kb_req, kb_bar, demo_en, demo_req, demo_bar, clear_req,
    input  kb_ack, demo_ack, busy, bar_lit, note_valid, note_bar, bad_idx
  );

  modport slave (
    input  frame_tick, kb_req, kb_bar, demo_en, demo_req, demo_bar, clear_req,
    output kb_ack, demo_ack, busy, bar_lit, note_valid, note_bar, bad_idx
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered priority pointer.
// Pointer flips only on contention, so a lone requester never steals the next turn.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;  // 0 favours req[0], 1 favours req[1]

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (req == 2'b11) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/bar_key_scheduler.sv
// Grants keyboard/demo notes onto per-bar frame hold counters; bar_lit is a shadow updated only on frame_tick.
// Grant effects appear one cycle later; requests hold until ack and simply wait out a clear sequence.
module bar_key_scheduler
  import bar_key_scheduler_pkg::*;
#(
  parameter int NUM_BARS    = DEF_NUM_BARS,
  parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  bar_key_scheduler_if.slave bus
);

  sched_state_t         state, state_nxt;
  bar_idx_t             clr_idx, clr_idx_nxt;
  logic                 grant_ok, clr_active;

  logic [CNT_W-1:0]     cnt     [NUM_BARS];
  logic [CNT_W-1:0]     cnt_nxt [NUM_BARS];
  logic [NUM_BARS-1:0]  bar_lit_q, lit_nxt;

  logic                 kb_ack_q, demo_ack_q, note_valid_q, bad_idx_q;
  bar_idx_t             note_bar_q;

  logic                 kb_elig, demo_elig;
  logic [1:0]           arb_req, gnt;
  logic                 gnt_any, gnt_in_range, load;
  bar_idx_t             gnt_bar;

  // A source whose ack is high this cycle is mid-handshake and must not be re-granted.
  assign kb_elig   = bus.kb_req & ~kb_ack_q;
  assign demo_elig = bus.demo_req & ~demo_ack_q & bus.demo_en;

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    grant_ok    = 1'b0;
    clr_active  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.clear_req) begin
          state_nxt   = ST_CLEAR;
          clr_idx_nxt = '0;
        end else begin
          grant_ok = 1'b1;
        end
      end
      ST_CLEAR: begin
        clr_active = 1'b1;
        if (clr_idx == BAR_IDX_W'(NUM_BARS - 1)) begin
          state_nxt = ST_IDLE;
        end else begin
          clr_idx_nxt = clr_idx + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign arb_req = grant_ok ? {demo_elig, kb_elig} : 2'b00;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (arb_req),
    .gnt   (gnt)
  );

  assign gnt_any      = |gnt;
  assign gnt_bar      = gnt[1] ? bus.demo_bar : bus.kb_bar;
  assign gnt_in_range = bar_in_range(gnt_bar, NUM_BARS);
  assign load         = gnt_any & gnt_in_range;

  // Priority within a bar: clear over load over frame decrement.
  always_comb begin
    lit_nxt = bar_lit_q;
    for (int i = 0; i < NUM_BARS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (bus.frame_tick && (cnt[i] != '0)) begin
        cnt_nxt[i] = cnt[i] - 1'b1;
      end
      if (load && (int'(gnt_bar) == i)) begin
        cnt_nxt[i] = CNT_W'(HOLD_FRAMES);
      end
      if (clr_active && (int'(clr_idx) == i)) begin
        cnt_nxt[i] = '0;
      end
      if (bus.frame_tick) begin
        lit_nxt[i] = (cnt_nxt[i] != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      clr_idx      <= '0;
      bar_lit_q    <= '0;
      kb_ack_q     <= 1'b0;
      demo_ack_q   <= 1'b0;
      note_valid_q <= 1'b0;
      bad_idx_q    <= 1'b0;
      note_bar_q   <= '0;
      for (int i = 0; i < NUM_BARS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      state        <= state_nxt;
      clr_idx      <= clr_idx_nxt;
      bar_lit_q    <= lit_nxt;
      kb_ack_q     <= gnt[0];
      demo_ack_q   <= gnt[1];
      note_valid_q <= load;
      bad_idx_q    <= gnt_any & ~gnt_in_range;
      if (load) begin
        note_bar_q <= gnt_bar;
      end
      for (int i = 0; i < NUM_BARS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  assign bus.kb_ack     = kb_ack_q;
  assign bus.demo_ack   = demo_ack_q;
  assign bus.busy       = (state == ST_CLEAR);
  assign bus.bar_lit    = bar_lit_q;
  assign bus.note_valid = note_valid_q;
  assign bus.note_bar   = note_bar_q;
  assign bus.bad_idx    = bad_idx_q;

endmodule

// File: tb/tb_bar_key_scheduler.sv
// Directed scenarios plus randomized traffic against an event-level reference model of the scheduler.
`timescale 1ns/1ps
module tb_bar_key_scheduler;
  import bar_key_scheduler_pkg::*;

  localparam int NB   = DEF_NUM_BARS;
  localparam int HOLD = DEF_HOLD_FRAMES;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bar_key_scheduler_if #(.N_BARS(NB)) bus ();

  bar_key_scheduler #(
    .NUM_BARS    (NB),
    .HOLD_FRAMES (HOLD),
    .CNT_W       (DEF_CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: remaining frames per bar and the displayed vector.
  int            m_cnt [NB];
  logic [NB-1:0] m_lit;
  bit            m_ptr_demo, m_clearing, m_kb_ack, m_demo_ack, m_nv, m_bad;
  int            m_cidx, m_note_bar;

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) m_cnt[i] = 0;
    m_lit = '0;
    m_ptr_demo = 0; m_clearing = 0; m_cidx = 0;
    m_kb_ack = 0; m_demo_ack = 0; m_nv = 0; m_bad = 0; m_note_bar = 0;
  endfunction

  function automatic void model_clock();
    bit kb_e, dm_e, win_kb;
    int gbar, load, clr;
    kb_e = bus.kb_req && !m_kb_ack;
    dm_e = bus.demo_req && !m_demo_ack && bus.demo_en;
    load = -1;
    clr  = -1;
    m_kb_ack = 0; m_demo_ack = 0; m_nv = 0; m_bad = 0;
    if (m_clearing) begin
      clr = m_cidx;
      if (m_cidx == NB - 1) m_clearing = 0;
      else m_cidx++;
    end else if (bus.clear_req) begin
      m_clearing = 1;
      m_cidx = 0;
    end else if (kb_e || dm_e) begin
      win_kb = kb_e && !(dm_e && m_ptr_demo);
      if (kb_e && dm_e) m_ptr_demo = !m_ptr_demo;
      gbar = win_kb ? int'(bus.kb_bar) : int'(bus.demo_bar);
      m_kb_ack = win_kb;
      m_demo_ack = !win_kb;
      if (gbar < NB) begin
        m_nv = 1; m_note_bar = gbar; load = gbar;
      end else begin
        m_bad = 1;
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (bus.frame_tick && m_cnt[i] > 0) m_cnt[i]--;
      if (i == load) m_cnt[i] = HOLD;
      if (i == clr) m_cnt[i] = 0;
      if (bus.frame_tick) m_lit[i] = (m_cnt[i] != 0);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else model_clock();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.frame_tick = 0; bus.kb_req = 0; bus.kb_bar = '0; bus.demo_en = 0;
    bus.demo_req = 0; bus.demo_bar = '0; bus.clear_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; step(); reset = 0;
  endtask

  task automatic pulse_tick(input int n);
    for (int k = 0; k < n; k++) begin
      bus.frame_tick = 1; step();
      bus.frame_tick = 0; step();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; step(); step(); reset = 0;
    checks++; if (bus.bar_lit !== '0) begin errors++; $display("FAIL reset_bar_lit got %h exp 0", bus.bar_lit); end
    checks++; if ({bus.kb_ack, bus.demo_ack, bus.busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ack_busy got %b exp 000", {bus.kb_ack, bus.demo_ack, bus.busy}); end
    checks++; if ({bus.note_valid, bus.bad_idx, bus.note_bar} !== 6'd0) begin
      errors++; $display("FAIL reset_note got %b exp 0", {bus.note_valid, bus.bad_idx, bus.note_bar}); end
  endtask

  task automatic test_single_note();
    do_reset();
    bus.kb_req = 1; bus.kb_bar = BAR_MU6; step();
    checks++; if ({bus.kb_ack, bus.note_valid, bus.note_bar} !== {1'b1, 1'b1, 4'd3}) begin
      errors++; $display("FAIL single_grant got ack=%b nv=%b bar=%0d exp 1 1 3", bus.kb_ack, bus.note_valid, bus.note_bar); end
    bus.kb_req = 0; step();
    checks++; if ({bus.kb_ack, bus.note_valid} !== 2'b00) begin
      errors++; $display("FAIL single_pulse got ack=%b nv=%b exp 0 0", bus.kb_ack, bus.note_valid); end
    pulse_tick(1);
    checks++; if (bus.bar_lit !== 11'h008) begin errors++; $display("FAIL single_tick1 got %h exp 008", bus.bar_lit); end
    pulse_tick(6);
    checks++; if (bus.bar_lit !== 11'h008) begin errors++; $display("FAIL single_tick7 got %h exp 008", bus.bar_lit); end
    pulse_tick(2);
    checks++; if (bus.bar_lit !== 11'h000) begin errors++; $display("FAIL single_tick9 got %h exp 000", bus.bar_lit); end
  endtask

  task automatic test_arbitration();
    do_reset();
    bus.demo_en = 1;
    bus.kb_req = 1; bus.kb_bar = BAR_HU2;
    bus.demo_req = 1; bus.demo_bar = BAR_LU5;
    step();
    checks++; if ({bus.kb_ack, bus.demo_ack, bus.note_bar} !== {1'b1, 1'b0, 4'd1}) begin
      errors++; $display("FAIL arb_first got kb=%b dm=%b bar=%0d exp 1 0 1", bus.kb_ack, bus.demo_ack, bus.note_bar); end
    bus.kb_req = 0; step();
    checks++; if ({bus.kb_ack, bus.demo_ack, bus.note_bar} !== {1'b0, 1'b1, 4'd9}) begin
      errors++; $display("FAIL arb_second got kb=%b dm=%b bar=%0d exp 0 1 9", bus.kb_ack, bus.demo_ack, bus.note_bar); end
    bus.demo_req = 0;
    pulse_tick(1);
    checks++; if (bus.bar_lit !== 11'h202) begin errors++; $display("FAIL arb_lit got %h exp 202", bus.bar_lit); end
  endtask

  task automatic test_demo_mask();
    bit got;
    bus.demo_en = 0; bus.demo_req = 1; bus.demo_bar = BAR_MU5;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++; if (bus.demo_ack !== 1'b0) begin errors++; $display("FAIL demo_masked cyc %0d got %b exp 0", k, bus.demo_ack); end
    end
    bus.demo_en = 1;
    got = 0;
    for (int k = 0; k < 2 && !got; k++) begin
      step();
      if (bus.demo_ack === 1'b1) got = 1;
    end
    bus.demo_req = 0;
    checks++; if (!got) begin errors++; $display("FAIL demo_unmask got no ack exp ack within 2"); end
    step();
  endtask

  task automatic test_bad_index();
    logic [NB-1:0] lit_before;
    lit_before = bus.bar_lit;
    bus.kb_req = 1; bus.kb_bar = 4'd12; step();
    checks++; if ({bus.kb_ack, bus.bad_idx, bus.note_valid} !== 3'b110) begin
      errors++; $display("FAIL bad_idx got ack/bad/nv=%b exp 110", {bus.kb_ack, bus.bad_idx, bus.note_valid}); end
    bus.kb_req = 0; step();
    checks++; if (bus.bar_lit !== lit_before || bus.bad_idx !== 1'b0) begin
      errors++; $display("FAIL bad_after got lit=%h bad=%b exp lit=%h bad=0", bus.bar_lit, bus.bad_idx, lit_before); end
    pulse_tick(1);
    checks++; if (bus.bar_lit !== m_lit) begin errors++; $display("FAIL bad_tick got %h exp %h", bus.bar_lit, m_lit); end
  endtask

  task automatic test_clear();
    int busy_cycles;
    bit ack_early;
    do_reset();
    for (int b = 0; b < NB; b++) begin
      bus.kb_req = 1; bus.kb_bar = 4'(b); step();
      bus.kb_req = 0; step();
    end
    pulse_tick(1);
    checks++; if (bus.bar_lit !== 11'h7ff) begin errors++; $display("FAIL clear_all_lit got %h exp 7ff", bus.bar_lit); end
    bus.clear_req = 1; bus.kb_req = 1; bus.kb_bar = BAR_MU2; step();
    bus.clear_req = 0;
    checks++; if ({bus.busy, bus.kb_ack} !== 2'b10) begin
      errors++; $display("FAIL clear_wins got busy=%b ack=%b exp 1 0", bus.busy, bus.kb_ack); end
    busy_cycles = 0; ack_early = 0;
    for (int k = 0; k < 40 && bus.busy === 1'b1; k++) begin
      busy_cycles++;
      if (bus.kb_ack === 1'b1) ack_early = 1;
      bus.clear_req = (k == 3);
      step();
    end
    bus.clear_req = 0;
    checks++; if (busy_cycles != NB) begin errors++; $display("FAIL clear_len got %0d exp %0d", busy_cycles, NB); end
    checks++; if (ack_early || bus.kb_ack !== 1'b0) begin errors++; $display("FAIL clear_hold got early ack exp none"); end
    step();
    checks++; if (bus.kb_ack !== 1'b1) begin errors++; $display("FAIL clear_resume got %b exp 1", bus.kb_ack); end
    bus.kb_req = 0;
    pulse_tick(1);
    checks++; if (bus.bar_lit !== 11'h040) begin errors++; $display("FAIL clear_new_lit got %h exp 040", bus.bar_lit); end
  endtask

  task automatic test_tick_load_reset();
    do_reset();
    bus.kb_req = 1; bus.kb_bar = BAR_MU4; bus.frame_tick = 1; step();
    bus.kb_req = 0; bus.frame_tick = 0;
    checks++; if ({bus.kb_ack, bus.bar_lit} !== {1'b1, 11'h020}) begin
      errors++; $display("FAIL tick_load got ack=%b lit=%h exp 1 020", bus.kb_ack, bus.bar_lit); end
    pulse_tick(7);
    checks++; if (bus.bar_lit !== 11'h020) begin errors++; $display("FAIL tick_load_hold got %h exp 020", bus.bar_lit); end
    reset = 1; step();
    checks++; if (bus.bar_lit !== '0) begin errors++; $display("FAIL mid_reset got %h exp 000", bus.bar_lit); end
    reset = 0;
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    do_reset();
    for (int c = 0; c < 3000 && errors < 30; c++) begin
      if (m_kb_ack) bus.kb_req = 0;
      else if (!bus.kb_req && $urandom_range(0, 3) == 0) begin
        bus.kb_req = 1; bus.kb_bar = 4'($urandom_range(0, 12));
      end
      if (m_demo_ack) bus.demo_req = 0;
      else if (!bus.demo_req && $urandom_range(0, 3) == 0) begin
        bus.demo_req = 1; bus.demo_bar = 4'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 15) == 0) bus.demo_en = ~bus.demo_en;
      bus.clear_req  = ($urandom_range(0, 60) == 0);
      bus.frame_tick = ($urandom_range(0, 4) == 0);
      reset          = ($urandom_range(0, 700) == 0);
      step();
      got = {bus.kb_ack, bus.demo_ack, bus.note_valid, bus.bad_idx, bus.busy, bus.note_bar, bus.bar_lit};
      exp = {m_kb_ack, m_demo_ack, m_nv, m_bad, m_clearing, 4'(m_note_bar), m_lit};
      checks++; if (got !== exp) begin errors++; $display("FAIL random cyc %0d got %h exp %h", c, got, exp); end
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_single_note();
    test_arbitration();
    test_demo_mask();
    test_bad_index();
    test_clear();
    test_tick_load_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
